// File: rtl/addsub_reg.sv
// Registered two's-complement adder/subtractor built on a ripple-carry chain.
// Result and status flags appear one cycle after the operands are accepted.
module addsub_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  logic p;

  assign p   = a_i ^ b_i;
  assign s_o = p ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & p);
endmodule

module addsub_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);
  logic [WIDTH-1:0] yb;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   c;

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] s_d, s_q;
  logic             cout_d, cout_q;
  logic             ovf_d, ovf_q;
  logic             zero_d, zero_q;
  logic             neg_d, neg_q;

  // Subtract inverts y and injects the +1 through the carry-in.
  assign yb   = y ^ {WIDTH{c_in}};
  assign c[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    addsub_fa u_fa (
      .a_i (x[i]),
      .b_i (yb[i]),
      .c_i (c[i]),
      .s_o (sum[i]),
      .c_o (c[i+1])
    );
  end

  always_comb begin
    valid_d = in_valid;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    if (in_valid) begin
      s_d    = sum;
      cout_d = c[WIDTH];
      ovf_d  = c[WIDTH] ^ c[WIDTH-1];
      zero_d = ~|sum;
      neg_d  = sum[WIDTH-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  assign out_valid = valid_q;
  assign s         = s_q;
  assign c_out     = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
endmodule

// File: tb/tb_addsub_reg.sv
// Scoreboard bench for addsub_reg: expected results are queued at issue
// and compared when the registered outputs become valid.
module tb_addsub_reg;
  localparam int W = 8;

  typedef logic [W+3:0] exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] s;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] x, y;
  logic         c_in;
  logic         out_valid;
  logic [W-1:0] s;
  logic         c_out, ovf, zero, neg;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  addsub_reg #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .x         (x),
    .y         (y),
    .c_in      (c_in),
    .out_valid (out_valid),
    .s         (s),
    .c_out     (c_out),
    .ovf       (ovf),
    .zero      (zero),
    .neg       (neg)
  );

  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b,
                                 logic sub);
    logic [W:0]   t;
    logic [W-1:0] bb;
    logic         v;
    bb = sub ? ~b : b;
    t  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub};
    if (sub) v = (a[W-1] != b[W-1]) && (t[W-1] != a[W-1]);
    else     v = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
    return {t[W], v, t[W-1:0] == '0, t[W-1], t[W-1:0]};
  endfunction

  function automatic exp_t got();
    return {c_out, ovf, zero, neg, s};
  endfunction

  task automatic issue(logic [W-1:0] a, logic [W-1:0] b, logic sub);
    in_valid = 1'b1;
    x        = a;
    y        = b;
    c_in     = sub;
    sb.push_back(model(a, b, sub));
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; x = 8'hAA; y = 8'h55; c_in = 1'b0;
    #1;
    checks++;
    if ({out_valid, got()} !== '0) begin
      errors++;
      $display("FAIL reset_async got=%b,%h required=0,0", out_valid, got());
    end
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, got()} !== '0) begin
      errors++;
      $display("FAIL reset_release got=%b,%h required=0,0", out_valid, got());
    end
  endtask

  task automatic test_add();
    vec_t v[3];
    v[0] = '{8'h0F, 8'h03, 1'b0, 8'h12};
    v[1] = '{8'h00, 8'h00, 1'b0, 8'h00};
    v[2] = '{8'h40, 8'h3F, 1'b0, 8'h7F};
    foreach (v[i]) begin
      @(negedge clk);
      issue(v[i].a, v[i].b, v[i].sub);
      @(negedge clk);
      in_valid = 1'b0;
      e = sb.size() > 0 ? sb.pop_front() : 'x;
      checks++;
      if (out_valid !== 1'b1 || got() !== e || s !== v[i].s) begin
        errors++;
        $display("FAIL add[%0d] got v=%b %h required v=1 %h s=%h",
                 i, out_valid, got(), e, v[i].s);
      end
    end
  endtask

  task automatic test_sub();
    vec_t v[4];
    v[0] = '{8'h0F, 8'h03, 1'b1, 8'h0C};
    v[1] = '{8'h03, 8'h0F, 1'b1, 8'hF4};
    v[2] = '{8'h5A, 8'h5A, 1'b1, 8'h00};
    v[3] = '{8'h00, 8'h01, 1'b1, 8'hFF};
    foreach (v[i]) begin
      @(negedge clk);
      issue(v[i].a, v[i].b, v[i].sub);
      @(negedge clk);
      in_valid = 1'b0;
      e = sb.size() > 0 ? sb.pop_front() : 'x;
      checks++;
      if (out_valid !== 1'b1 || got() !== e || s !== v[i].s) begin
        errors++;
        $display("FAIL sub[%0d] got v=%b %h required v=1 %h s=%h",
                 i, out_valid, got(), e, v[i].s);
      end
    end
  endtask

  task automatic test_wrap_ovf();
    vec_t v[4];
    v[0] = '{8'hFF, 8'h01, 1'b0, 8'h00};
    v[1] = '{8'h7F, 8'h01, 1'b0, 8'h80};
    v[2] = '{8'h80, 8'h01, 1'b1, 8'h7F};
    v[3] = '{8'h80, 8'h80, 1'b0, 8'h00};
    foreach (v[i]) begin
      @(negedge clk);
      issue(v[i].a, v[i].b, v[i].sub);
      @(negedge clk);
      in_valid = 1'b0;
      e = sb.size() > 0 ? sb.pop_front() : 'x;
      checks++;
      if (out_valid !== 1'b1 || got() !== e || s !== v[i].s) begin
        errors++;
        $display("FAIL wrap_ovf[%0d] got v=%b %h required v=1 %h s=%h",
                 i, out_valid, got(), e, v[i].s);
      end
    end
  endtask

  task automatic test_hold();
    exp_t last;
    @(negedge clk);
    issue(8'h81, 8'h02, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    x = 8'h11; y = 8'h22; c_in = 1'b1;
    last = sb.size() > 0 ? sb.pop_front() : 'x;
    checks++;
    if (out_valid !== 1'b1 || got() !== last) begin
      errors++;
      $display("FAIL hold_load got v=%b %h required v=1 %h",
               out_valid, got(), last);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || got() !== last) begin
      errors++;
      $display("FAIL hold_idle got v=%b %h required v=0 %h",
               out_valid, got(), last);
    end
  endtask

  task automatic test_back_to_back();
    int n = 24;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = sb.size() > 0 ? sb.pop_front() : 'x;
        checks++;
        if (out_valid !== 1'b1 || got() !== e) begin
          errors++;
          $display("FAIL b2b[%0d] got v=%b %h required v=1 %h",
                   i - 1, out_valid, got(), e);
        end
      end
      if (i < n)
        issue(W'($urandom), W'($urandom), 1'($urandom));
      else
        in_valid = 1'b0;
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    issue(8'h0F, 8'h03, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    e = sb.size() > 0 ? sb.pop_front() : 'x;
    checks++;
    if (out_valid !== 1'b1 || got() !== e) begin
      errors++;
      $display("FAIL t6_pre got v=%b %h required v=1 %h",
               out_valid, got(), e);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, got()} !== '0) begin
      errors++;
      $display("FAIL t6_async got=%b,%h required=0,0", out_valid, got());
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, got()} !== '0) begin
      errors++;
      $display("FAIL t6_release got=%b,%h required=0,0", out_valid, got());
    end
    issue(8'h7F, 8'h01, 1'b0);
    #2 rst = 1'b1;
    sb.delete();
    #1;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, got()} !== '0) begin
      errors++;
      $display("FAIL inflight_drop got=%b,%h required=0,0",
               out_valid, got());
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_wrap_ovf();
    test_hold();
    test_back_to_back();
    test_mid_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
